clk_div_ctrl: RTL and testbench

- Runtime-programmable power-of-two clock divider controller for the clock-division datapath.
- Owns one free-running counter and drives a divided clock output `clk_out` as one counter bit.
- Accepts divide-ratio change requests over a req/ack handshake and applies each change only at a period boundary, so `clk_out` never produces a runt pulse.
- Also emits a one-cycle `tick` enable strobe per divided period for downstream logic clocked on `clk`.

---
 rtl/clk_div_ctrl.sv | 165 ++++++++++++++++
 tb/tb_clk_div_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_ctrl.sv
// ---------------------------------------------------------------------------
// clk_div_ctrl
// Runtime-programmable power-of-two clock divider controller. A free-running
// counter drives the divided clock clk_out = cnt[cur_sel]. Ratio changes
// arrive over a req/ack handshake and are applied only at a period boundary.
// This keeps clk_out free of runt pulses. A one-cycle tick strobe marks the
// first clk cycle of every divided period.
//
// Optional feature macro: CLKDIV_CTRL_SYNC_REQ_EN
//   When defined, sel_req/div_sel pass through a 2-flop synchronizer, which
//   adds 2 cycles of request latency. The requester must hold div_sel stable
//   until sel_ack.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   en       in   count enable; freezes counter and boundary detection
//   div_sel  in   requested divide select (ratio = 2^(sel+1))
//   sel_req  in   ratio change request
//   sel_ack  out  one-cycle pulse: new ratio active
//   busy     out  request pending or being acknowledged
//   cur_sel  out  divide select in effect
//   clk_out  out  divided clock, 50% duty
//   tick     out  one-cycle strobe at the start of each divided period
// ---------------------------------------------------------------------------
module clk_div_ctrl #(
    parameter int unsigned SEL_W   = 2,
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned RST_SEL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [SEL_W-1:0] div_sel,
    input  logic             sel_req,
    output logic             sel_ack,
    output logic             busy,
    output logic [SEL_W-1:0] cur_sel,
    output logic             clk_out,
    output logic             tick
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PEND = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    state_e             state_q,    state_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic [SEL_W-1:0]   cur_sel_q,  cur_sel_d;
    logic [SEL_W-1:0]   pend_sel_q, pend_sel_d;
    logic               sel_ack_q,  sel_ack_d;
    logic               busy_q,     busy_d;
    logic               clk_out_q,  clk_out_d;
    logic               tick_q,     tick_d;

    logic               req_s;
    logic [SEL_W-1:0]   sel_s;
    logic [CNT_W-1:0]   mask_c;
    logic               bnd_c;

`ifdef CLKDIV_CTRL_SYNC_REQ_EN
    logic               req_meta_q, req_sync_q;
    logic [SEL_W-1:0]   sel_meta_q, sel_sync_q;

    // Two-flop synchronizer for requests from a foreign clock domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_meta_q <= 1'b0;
            req_sync_q <= 1'b0;
            sel_meta_q <= '0;
            sel_sync_q <= '0;
        end else begin
            req_meta_q <= sel_req;
            req_sync_q <= req_meta_q;
            sel_meta_q <= div_sel;
            sel_sync_q <= sel_meta_q;
        end
    end

    assign req_s = req_sync_q;
    assign sel_s = sel_sync_q;
`else
    assign req_s = sel_req;
    assign sel_s = div_sel;
`endif

    // Mask of counter bits [cur_sel:0]; all ones there marks the period end
    always_comb begin
        mask_c = '0;
        for (int unsigned i = 0; i < CNT_W; i++) begin
            mask_c[i] = (i <= 32'(cur_sel_q));
        end
    end

    assign bnd_c = en && ((cnt_q & mask_c) == mask_c);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            cnt_q      <= '0;
            cur_sel_q  <= SEL_W'(RST_SEL);
            pend_sel_q <= '0;
            sel_ack_q  <= 1'b0;
            busy_q     <= 1'b0;
            clk_out_q  <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_sel_q  <= cur_sel_d;
            pend_sel_q <= pend_sel_d;
            sel_ack_q  <= sel_ack_d;
            busy_q     <= busy_d;
            clk_out_q  <= clk_out_d;
            tick_q     <= tick_d;
        end
    end

    // Next-state, counter and output logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = en ? (cnt_q + CNT_W'(1)) : cnt_q;
        cur_sel_d  = cur_sel_q;
        pend_sel_d = pend_sel_q;

        case (state_q)
            ST_RUN: begin
                if (req_s) begin
                    pend_sel_d = sel_s;
                    state_d    = ST_PEND;
                end
            end
            ST_PEND: begin
                // Switch only at the end of a full period; restart phase at 0
                if (bnd_c) begin
                    cur_sel_d = pend_sel_q;
                    cnt_d     = '0;
                    state_d   = ST_ACK;
                end
            end
            ST_ACK: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // Registered outputs follow the state/counter being loaded this edge
        busy_d    = (state_d != ST_RUN);
        sel_ack_d = (state_d == ST_ACK);
        tick_d    = bnd_c;
        clk_out_d = cnt_d[cur_sel_d];
    end

    assign sel_ack = sel_ack_q;
    assign busy    = busy_q;
    assign cur_sel = cur_sel_q;
    assign clk_out = clk_out_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clk_div_ctrl
// Directed self-checking bench for clk_div_ctrl (default parameters).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_clk_div_ctrl;

    localparam int unsigned SEL_W = 2;
`ifdef CLKDIV_CTRL_SYNC_REQ_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic             clk;
    logic             rst_n;
    logic             en;
    logic [SEL_W-1:0] div_sel;
    logic             sel_req;
    logic             sel_ack;
    logic             busy;
    logic [SEL_W-1:0] cur_sel;
    logic             clk_out;
    logic             tick;

    int n_checks;
    int n_fail;
    int lat;

    clk_div_ctrl #(.SEL_W(2), .CNT_W(4), .RST_SEL(0)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .div_sel (div_sel),
        .sel_req (sel_req),
        .sel_ack (sel_ack),
        .busy    (busy),
        .cur_sel (cur_sel),
        .clk_out (clk_out),
        .tick    (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for sel_ack; lat counts edges already taken by the caller
    task automatic wait_ack();
        while (sel_ack !== 1'b1 && lat < 40) begin
            cycle();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; sel_req = 1'b0; div_sel = '0;
        #3;
        n_checks++; if (sel_ack !== 1'b0) begin n_fail++; $display("FAIL reset_sel_ack got %b exp 0", sel_ack); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_checks++; if (cur_sel !== 2'd0) begin n_fail++; $display("FAIL reset_cur_sel got %0d exp 0", cur_sel); end
        n_checks++; if (clk_out !== 1'b0) begin n_fail++; $display("FAIL reset_clk_out got %b exp 0", clk_out); end
        n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick got %b exp 0", tick); end
        cycle();
        cycle();
        rst_n = 1'b1;
        en    = 1'b1;
    endtask

    // Divide by 2 out of reset: cnt = k after k edges
    task automatic test_div2();
        logic e_clk, e_tick;
        for (int k = 1; k <= 8; k++) begin
            cycle();
            e_clk  = 1'((k % 2) == 1);
            e_tick = 1'((k % 2) == 0);
            n_checks++; if (clk_out !== e_clk) begin n_fail++; $display("FAIL div2_clk_out k=%0d got %b exp %b", k, clk_out, e_clk); end
            n_checks++; if (tick !== e_tick) begin n_fail++; $display("FAIL div2_tick k=%0d got %b exp %b", k, tick, e_tick); end
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL div2_busy k=%0d got %b exp 0", k, busy); end
            n_checks++; if (cur_sel !== 2'd0) begin n_fail++; $display("FAIL div2_cur_sel k=%0d got %0d exp 0", k, cur_sel); end
        end
    endtask

    // /2 -> /16, request sampled at cnt=1
    task automatic test_switch_up();
        logic e_clk, e_tick;
        cycle();
        n_checks++; if (clk_out !== 1'b1) begin n_fail++; $display("FAIL up_pre_clk_out got %b exp 1", clk_out); end
        sel_req = 1'b1; div_sel = 2'd3;
        cycle();
        sel_req = 1'b0;
        lat = 1;
        wait_ack();
        n_checks++; if (lat !== 3 + SYNC_LAT) begin n_fail++; $display("FAIL up_latency got %0d exp %0d", lat, 3 + SYNC_LAT); end
        n_checks++; if (cur_sel !== 2'd3) begin n_fail++; $display("FAIL up_cur_sel got %0d exp 3", cur_sel); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL up_ack_busy got %b exp 1", busy); end
        for (int k = 0; k < 32; k++) begin
            e_clk  = 1'((k % 16) >= 8);
            e_tick = 1'((k % 16) == 0);
            n_checks++; if (clk_out !== e_clk) begin n_fail++; $display("FAIL up_clk_out k=%0d got %b exp %b", k, clk_out, e_clk); end
            n_checks++; if (tick !== e_tick) begin n_fail++; $display("FAIL up_tick k=%0d got %b exp %b", k, tick, e_tick); end
            if (k > 0) begin
                n_checks++; if (sel_ack !== 1'b0) begin n_fail++; $display("FAIL up_sel_ack k=%0d got %b exp 0", k, sel_ack); end
                n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL up_busy k=%0d got %b exp 0", k, busy); end
            end
            cycle();
        end
    endtask

    // /16 -> /4, request at cnt=5, switch at cnt=15
    task automatic test_switch_down();
        logic e_clk, e_tick;
        repeat (5) cycle();
        n_checks++; if (clk_out !== 1'b0) begin n_fail++; $display("FAIL down_pre_clk_out got %b exp 0", clk_out); end
        sel_req = 1'b1; div_sel = 2'd1;
        cycle();
        sel_req = 1'b0;
        repeat (4) cycle();
        lat = 5;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL down_mid_busy got %b exp 1", busy); end
        n_checks++; if (clk_out !== 1'b1) begin n_fail++; $display("FAIL down_mid_clk_out got %b exp 1", clk_out); end
        n_checks++; if (cur_sel !== 2'd3) begin n_fail++; $display("FAIL down_mid_cur_sel got %0d exp 3", cur_sel); end
        wait_ack();
        n_checks++; if (lat !== 11) begin n_fail++; $display("FAIL down_latency got %0d exp 11", lat); end
        n_checks++; if (cur_sel !== 2'd1) begin n_fail++; $display("FAIL down_cur_sel got %0d exp 1", cur_sel); end
        for (int k = 0; k < 8; k++) begin
            e_clk  = 1'((k % 4) >= 2);
            e_tick = 1'((k % 4) == 0);
            n_checks++; if (clk_out !== e_clk) begin n_fail++; $display("FAIL down_clk_out k=%0d got %b exp %b", k, clk_out, e_clk); end
            n_checks++; if (tick !== e_tick) begin n_fail++; $display("FAIL down_tick k=%0d got %b exp %b", k, tick, e_tick); end
            if (k > 0) begin
                n_checks++; if (sel_ack !== 1'b0) begin n_fail++; $display("FAIL down_sel_ack k=%0d got %b exp 0", k, sel_ack); end
            end
            cycle();
        end
    endtask

    // Drop en while PEND sits on a boundary cycle; nothing may advance
    task automatic test_en_freeze();
        sel_req = 1'b1; div_sel = 2'd0;
        cycle();
        sel_req = 1'b0;
        cycle();
        cycle();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL frz_pre_busy got %b exp 1", busy); end
        n_checks++; if (clk_out !== 1'b1) begin n_fail++; $display("FAIL frz_pre_clk_out got %b exp 1", clk_out); end
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL frz_tick k=%0d got %b exp 0", k, tick); end
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL frz_busy k=%0d got %b exp 1", k, busy); end
            n_checks++; if (clk_out !== 1'b1) begin n_fail++; $display("FAIL frz_clk_out k=%0d got %b exp 1", k, clk_out); end
            n_checks++; if (sel_ack !== 1'b0) begin n_fail++; $display("FAIL frz_sel_ack k=%0d got %b exp 0", k, sel_ack); end
            n_checks++; if (cur_sel !== 2'd1) begin n_fail++; $display("FAIL frz_cur_sel k=%0d got %0d exp 1", k, cur_sel); end
        end
        en = 1'b1;
        cycle();
        n_checks++; if (sel_ack !== 1'b1) begin n_fail++; $display("FAIL frz_resume_ack got %b exp 1", sel_ack); end
        n_checks++; if (cur_sel !== 2'd0) begin n_fail++; $display("FAIL frz_resume_cur_sel got %0d exp 0", cur_sel); end
        n_checks++; if (clk_out !== 1'b0) begin n_fail++; $display("FAIL frz_resume_clk_out got %b exp 0", clk_out); end
        n_checks++; if (tick !== 1'b1) begin n_fail++; $display("FAIL frz_resume_tick got %b exp 1", tick); end
        cycle();
        n_checks++; if (sel_ack !== 1'b0) begin n_fail++; $display("FAIL frz_post_ack got %b exp 0", sel_ack); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL frz_post_busy got %b exp 0", busy); end
        n_checks++; if (clk_out !== 1'b1) begin n_fail++; $display("FAIL frz_post_clk_out got %b exp 1", clk_out); end
    endtask

    // Same select as current still waits for the boundary and acks
    task automatic test_same_sel();
        sel_req = 1'b1; div_sel = 2'd0;
        cycle();
        sel_req = 1'b0;
        lat = 1;
        wait_ack();
        n_checks++; if (lat !== 3 + SYNC_LAT) begin n_fail++; $display("FAIL same_latency got %0d exp %0d", lat, 3 + SYNC_LAT); end
        n_checks++; if (cur_sel !== 2'd0) begin n_fail++; $display("FAIL same_cur_sel got %0d exp 0", cur_sel); end
        n_checks++; if (clk_out !== 1'b0) begin n_fail++; $display("FAIL same_clk_out got %b exp 0", clk_out); end
    endtask

    // sel_req held high across ACK is re-taken in RUN
    task automatic test_back_to_back();
        cycle();
        sel_req = 1'b1; div_sel = 2'd1;
        lat = 0;
        wait_ack();
        n_checks++; if (sel_ack !== 1'b1) begin n_fail++; $display("FAIL b2b_first_ack got %b exp 1", sel_ack); end
        cycle();
        n_checks++; if (sel_ack !== 1'b0) begin n_fail++; $display("FAIL b2b_gap_ack got %b exp 0", sel_ack); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_gap_busy got %b exp 0", busy); end
        lat = 1;
        wait_ack();
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL b2b_second_latency got %0d exp 4", lat); end
        n_checks++; if (cur_sel !== 2'd1) begin n_fail++; $display("FAIL b2b_cur_sel got %0d exp 1", cur_sel); end
        sel_req = 1'b0;
        repeat (16) cycle();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_busy got %b exp 0", busy); end
    endtask

    // Reset while PEND drops the request without an ack
    task automatic test_reset_mid_pend();
        logic e_clk;
        sel_req = 1'b1; div_sel = 2'd3;
        cycle();
        sel_req = 1'b0;
        lat = 1;
        while (busy !== 1'b1 && lat < 10) begin
            cycle();
            lat++;
        end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstp_pend_busy got %b exp 1", busy); end
        n_checks++; if (sel_ack !== 1'b0) begin n_fail++; $display("FAIL rstp_pend_ack got %b exp 0", sel_ack); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstp_busy got %b exp 0", busy); end
        n_checks++; if (cur_sel !== 2'd0) begin n_fail++; $display("FAIL rstp_cur_sel got %0d exp 0", cur_sel); end
        n_checks++; if (clk_out !== 1'b0) begin n_fail++; $display("FAIL rstp_clk_out got %b exp 0", clk_out); end
        n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL rstp_tick got %b exp 0", tick); end
        cycle();
        cycle();
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            cycle();
            e_clk = 1'((k % 2) == 1);
            n_checks++; if (sel_ack !== 1'b0) begin n_fail++; $display("FAIL rstp_post_ack k=%0d got %b exp 0", k, sel_ack); end
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstp_post_busy k=%0d got %b exp 0", k, busy); end
            n_checks++; if (cur_sel !== 2'd0) begin n_fail++; $display("FAIL rstp_post_cur_sel k=%0d got %0d exp 0", k, cur_sel); end
            n_checks++; if (clk_out !== e_clk) begin n_fail++; $display("FAIL rstp_post_clk_out k=%0d got %b exp %b", k, clk_out, e_clk); end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        lat      = 0;
        test_reset();
        test_div2();
        test_switch_up();
        test_switch_down();
        test_en_freeze();
        test_same_sel();
        test_back_to_back();
        test_reset_mid_pend();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got running exp finished");
        $fatal(1, "watchdog");
    end

endmodule
